frame_gain_stage: RTL

- Per-frame stereo gain and soft-mute stage between the I2S receiver output and the sample FIFO write side.
- Processes one left/right sample pair per rising edge of pin_i2s_fclk.
- Applies a ramped gain, so unmute, mute and gain changes never step abruptly and cause pops.
- Reports per-channel peak magnitude over a fixed window of frames, for level LEDs and debug.

---
 rtl/frame_gain_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/frame_gain_stage.sv
// Stereo ramped-gain / soft-mute stage with windowed peak metering.
// One left/right pair per pin_i2s_fclk edge; data latency is one frame.

// Per-channel gain multiply, output register and peak tracking.
module frame_gain_lane #(
    parameter int WIDTH = 32
) (
    input  logic             pin_i2s_fclk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             win_end,
    input  logic [8:0]       gain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-2:0] peak
);
    logic signed [WIDTH+9:0] prod;
    logic [WIDTH-1:0]        dout_nxt;
    logic [WIDTH-1:0]        mag;
    logic [WIDTH-2:0]        abs_cur;
    logic [WIDTH-2:0]        acc;
    logic [WIDTH-2:0]        acc_max;
    logic                    unused_prod;

    // Signed sample times unsigned gain; gain <= 256 keeps the product in WIDTH+9 bits.
    always_comb begin
        prod     = $signed({{10{din[WIDTH-1]}}, din}) * $signed({{WIDTH{1'b0}}, 1'b0, gain});
        dout_nxt = prod[WIDTH+7:8];
        mag      = dout_nxt[WIDTH-1] ? -dout_nxt : dout_nxt;
        // Only the most negative code leaves mag's MSB set; saturate it.
        abs_cur  = mag[WIDTH-1] ? {(WIDTH-1){1'b1}} : mag[WIDTH-2:0];
        acc_max  = (abs_cur > acc) ? abs_cur : acc;
    end

    assign unused_prod = ^{prod[WIDTH+9:WIDTH+8], prod[7:0]};

    // Output register and running window maximum; everything holds on invalid frames.
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            dout <= '0;
            acc  <= '0;
            peak <= '0;
        end else if (in_valid) begin
            dout <= dout_nxt;
            if (win_end) begin
                peak <= acc_max;
                acc  <= '0;
            end else begin
                acc  <= acc_max;
            end
        end
    end
endmodule

// Top: shared gain ramp, mute FSM and peak window counter.
module frame_gain_stage #(
    parameter int WIDTH       = 32,
    parameter int RAMP_STEP   = 1,
    parameter int PEAK_FRAMES = 4800
) (
    input  logic             pin_i2s_fclk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_left_in,
    input  logic [WIDTH-1:0] data_right_in,
    input  logic             mute_req,
    input  logic [8:0]       target_gain,
    output logic [WIDTH-1:0] data_left_out,
    output logic [WIDTH-1:0] data_right_out,
    output logic             out_valid,
    output logic [8:0]       current_gain,
    output logic             muted,
    output logic [WIDTH-2:0] peak_left,
    output logic [WIDTH-2:0] peak_right,
    output logic             peak_update
);
    localparam int NUM_LANES = 2;
    localparam int CW        = $clog2(PEAK_FRAMES);

    localparam logic [CW-1:0] CNT_LAST = CW'(PEAK_FRAMES - 1);
    localparam logic [9:0]    STEP     = 10'(RAMP_STEP);

    localparam logic [1:0] ST_MUTED     = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd2;
    localparam logic [1:0] ST_STEADY    = 2'd3;

    logic [8:0]    gain;
    logic [8:0]    gain_nxt;
    logic [8:0]    tgt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] win_cnt;
    logic          win_end;

    logic [NUM_LANES-1:0][WIDTH-1:0] din_arr;
    logic [NUM_LANES-1:0][WIDTH-1:0] dout_arr;
    logic [NUM_LANES-1:0][WIDTH-2:0] peak_arr;

    // Effective target, next ramp step (never overshooting) and next FSM state.
    always_comb begin
        tgt = mute_req ? 9'd0 : ((target_gain > 9'd256) ? 9'd256 : target_gain);

        gain_nxt = gain;
        if (gain > tgt) begin
            gain_nxt = ({1'b0, gain - tgt} > STEP) ? (gain - STEP[8:0]) : tgt;
        end else if (gain < tgt) begin
            gain_nxt = ({1'b0, tgt - gain} > STEP) ? (gain + STEP[8:0]) : tgt;
        end

        if (gain_nxt == 9'd0 && mute_req) state_nxt = ST_MUTED;
        else if (gain_nxt > tgt)          state_nxt = ST_RAMP_DOWN;
        else if (gain_nxt < tgt)          state_nxt = ST_RAMP_UP;
        else                              state_nxt = ST_STEADY;
    end

    // Gain and state advance only on valid frames so gaps freeze the ramp.
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            gain  <= 9'd0;
            state <= ST_MUTED;
        end else if (in_valid) begin
            gain  <= gain_nxt;
            state <= state_nxt;
        end
    end

    assign win_end = (win_cnt == CNT_LAST);

    // Window counter over valid frames, plus the output strobes.
    always_ff @(posedge pin_i2s_fclk) begin
        if (rst) begin
            win_cnt     <= '0;
            out_valid   <= 1'b0;
            peak_update <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            peak_update <= in_valid && win_end;
            if (in_valid) win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        end
    end

    assign din_arr = {data_right_in, data_left_in};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        frame_gain_lane #(.WIDTH(WIDTH)) u_lane (
            .pin_i2s_fclk (pin_i2s_fclk),
            .rst          (rst),
            .in_valid     (in_valid),
            .win_end      (win_end),
            .gain         (gain),
            .din          (din_arr[i]),
            .dout         (dout_arr[i]),
            .peak         (peak_arr[i])
        );
    end

    assign data_left_out  = dout_arr[0];
    assign data_right_out = dout_arr[1];
    assign peak_left      = peak_arr[0];
    assign peak_right     = peak_arr[1];
    assign current_gain   = gain;
    assign muted          = (state == ST_MUTED);
endmodule
